// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline front end: widths, the canonical NOP
// and the fetch state encoding.
package riscv_pkg;

   localparam int XLEN = 64;
   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      KILL
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {PC, instruction} pairs sitting between fetch and decode.
// The head entry is read straight out of registered storage; flush wins over push.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW = XLEN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [AW-1:0]     pushPc_i,
   input  logic [INST_W-1:0] pushInstr_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic              empty_o,
   output logic [AW-1:0]     headPc_o,
   output logic [INST_W-1:0] headInstr_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]     pcMem_q    [DEPTH];
   logic [INST_W-1:0] instrMem_q [DEPTH];
   logic [PW-1:0]     rdPtr_q, wrPtr_q;
   logic [CW-1:0]     count_q;

   // Storage is cleared on reset so the decode-facing outputs read as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pcMem_q[i]    <= '0;
            instrMem_q[i] <= '0;
         end
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            pcMem_q[wrPtr_q]    <= pushPc_i;
            instrMem_q[wrPtr_q] <= pushInstr_i;
            wrPtr_q             <= wrPtr_q + PW'(1);
         end
         if (pop_i) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count_o     = count_q;
   assign empty_o     = (count_q == '0);
   assign headPc_o    = pcMem_q[rdPtr_q];
   assign headInstr_o = instrMem_q[rdPtr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps one request outstanding to
// instruction memory, buffers responses and hands them to decode over IF/ID.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              id_ready,
   output logic              IFID_valid,
   output logic [INST_W-1:0] IFID_instruction,
   output logic [XLEN-1:0]   IFID_PC_Out
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetchPc_q, fetchPc_d;
   logic [XLEN-1:0] reqAddr_q, reqAddr_d;

   logic [CW-1:0] count;
   logic          empty;
   logic          push, pop, issue;
   logic          space, spaceAfterPush;

   // Room is judged against the buffer plus any in-flight word; a pop in the same
   // cycle is deliberately not credited.
   assign space          = (int'(count) + int'(state_q == WAIT)) < DEPTH;
   assign spaceAfterPush = (int'(count) + 1) < DEPTH;

   always_comb begin
      state_d   = state_q;
      fetchPc_d = fetchPc_q;
      reqAddr_d = reqAddr_q;
      issue     = 1'b0;
      push      = 1'b0;
      if (redirect) begin
         fetchPc_d = {redirect_pc[XLEN-1:2], 2'b00};
         case (state_q)
            WAIT:    state_d = imem_ack ? IDLE : KILL;
            // The stale request completing alongside a redirect frees us to restart.
            KILL:    state_d = imem_ack ? IDLE : KILL;
            default: state_d = state_q;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (space) begin
                  issue     = 1'b1;
                  reqAddr_d = fetchPc_q;
                  fetchPc_d = fetchPc_q + XLEN'(4);
                  state_d   = WAIT;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  push = 1'b1;
                  if (spaceAfterPush) begin
                     issue     = 1'b1;
                     reqAddr_d = fetchPc_q;
                     fetchPc_d = fetchPc_q + XLEN'(4);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            KILL: begin
               if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         fetchPc_q <= RESET_PC;
         reqAddr_q <= RESET_PC;
      end else begin
         state_q   <= state_d;
         fetchPc_q <= fetchPc_d;
         reqAddr_q <= reqAddr_d;
      end
   end

   // Reset must silence the request even though IDLE with an empty buffer would issue.
   assign imem_req  = issue & ~reset;
   assign imem_addr = fetchPc_q;
   assign pop       = ~empty & id_ready & ~redirect;

   fetch_fifo #(
      .DEPTH(DEPTH),
      .AW   (XLEN)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .pop_i      (pop),
      .flush_i    (redirect),
      .pushPc_i   (reqAddr_q),
      .pushInstr_i(imem_rdata),
      .count_o    (count),
      .empty_o    (empty),
      .headPc_o   (IFID_PC_Out),
      .headInstr_o(IFID_instruction)
   );

   assign IFID_valid = ~empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector tables, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int DEPTH = 2;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        id_ready;
   logic        IFID_valid;
   logic [31:0] IFID_instruction;
   logic [63:0] IFID_PC_Out;

   fetch_unit #(
      .XLEN    (64),
      .RESET_PC(RESET_PC),
      .DEPTH   (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .id_ready        (id_ready),
      .IFID_valid      (IFID_valid),
      .IFID_instruction(IFID_instruction),
      .IFID_PC_Out     (IFID_PC_Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          doReset;
      bit          redir;
      logic [63:0] rpc;
      bit          rdy;
      bit          ack;
      logic [31:0] rdata;
      bit          expReq;
      logic [63:0] expAddr;
      bit          expValid;
      logic [63:0] expPc;
      logic [31:0] expInstr;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   int checks = 0;
   int passes = 0;

   // Reference model: buffered words, one in-flight request, its fate, next fetch PC.
   entry_t      modelQ[$];
   bit          outstanding;
   bit          stale;
   logic [63:0] mFetchPc;
   logic [63:0] mReqAddr;
   int          memLeft;
   int          fixedLat;
   int          popCount;
   logic [63:0] lastPopPc;
   int          obsReqCount;
   logic [63:0] lastObsReqAddr;

   function automatic logic [31:0] memWord(input logic [63:0] addr);
      if (addr == 64'h0) return 32'h0030_0293;
      return ((addr[31:0] ^ addr[63:32]) * 32'h9E37_79B1) + 32'h13;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic resetModel();
      modelQ.delete();
      outstanding = 1'b0;
      stale       = 1'b0;
      mFetchPc    = RESET_PC;
      mReqAddr    = RESET_PC;
      memLeft     = 0;
   endtask

   // Leaves the bench at a falling edge with the DUT freshly out of reset.
   task automatic doReset();
      reset       = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      id_ready    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      resetModel();
   endtask

   task automatic checkOutput(input string tag, input bit expReq);
      check({tag, ".req"}, 64'(imem_req), 64'(expReq));
      if (expReq) check({tag, ".addr"}, imem_addr, mFetchPc);
      check({tag, ".valid"}, 64'(IFID_valid), 64'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
         check({tag, ".pc"}, IFID_PC_Out, modelQ[0].pc);
         check({tag, ".instr"}, 64'(IFID_instruction), 64'(modelQ[0].instr));
      end
   endtask

   // One clock cycle of model-driven traffic; memory answers the model's request.
   task automatic applyStimulus(input string tag, input bit redir, input logic [63:0] rpc,
                                input bit rdy, input bit forceAck);
      bit          ack;
      bit          expReq;
      logic [31:0] rdata;
      entry_t      e;
      ack   = 1'b0;
      rdata = $urandom;
      if (outstanding) begin
         memLeft--;
         if (memLeft <= 0) begin
            ack   = 1'b1;
            rdata = memWord(mReqAddr);
         end
      end
      if (forceAck && !outstanding) begin
         ack   = 1'b1;
         rdata = 32'hDEAD_BEEF;
      end
      imem_ack    = ack;
      imem_rdata  = rdata;
      redirect    = redir;
      redirect_pc = rpc;
      id_ready    = rdy;

      if (redir) expReq = 1'b0;
      else if (!outstanding) expReq = modelQ.size() < DEPTH;
      else if (ack && !stale) expReq = (modelQ.size() + 1) < DEPTH;
      else expReq = 1'b0;

      #1;
      checkOutput(tag, expReq);
      if (imem_req) begin
         obsReqCount++;
         lastObsReqAddr = imem_addr;
      end

      if (modelQ.size() > 0 && rdy && !redir) begin
         lastPopPc = modelQ[0].pc;
         popCount++;
         void'(modelQ.pop_front());
      end
      if (ack && outstanding) begin
         if (!stale && !redir) begin
            e.pc    = mReqAddr;
            e.instr = rdata;
            modelQ.push_back(e);
         end
         outstanding = 1'b0;
         stale       = 1'b0;
      end
      if (redir) begin
         modelQ.delete();
         mFetchPc = {rpc[63:2], 2'b00};
         if (outstanding) stale = 1'b1;
      end
      if (expReq) begin
         outstanding = 1'b1;
         stale       = 1'b0;
         mReqAddr    = mFetchPc;
         mFetchPc    = mFetchPc + 64'd4;
         memLeft     = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
      end
      @(negedge clk);
   endtask

   vec_t vecs[11];

   initial begin
      int          startPops;
      int          bound;
      logic [63:0] rpc;
      reset = 1'b1;
      imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      fixedLat = 1; popCount = 0; obsReqCount = 0; lastPopPc = '0; lastObsReqAddr = '0;
      resetModel();
      #2;
      check("reset.req", 64'(imem_req), 64'd0);
      check("reset.addr", imem_addr, RESET_PC);
      check("reset.valid", 64'(IFID_valid), 64'd0);
      check("reset.instr", 64'(IFID_instruction), 64'd0);
      check("reset.pc", IFID_PC_Out, 64'd0);

      // Startup with a one-cycle memory, then a redirect to 0x83 landing on an ack.
      vecs[0]  = '{1, 0, 0, 1, 0, 0,              1, 64'h0,  0, 0, 0};
      vecs[1]  = '{0, 0, 0, 1, 1, memWord(0),     1, 64'h4,  0, 0, 0};
      vecs[2]  = '{0, 0, 0, 1, 1, memWord(4),     0, 0,      1, 64'h0, 32'h0030_0293};
      vecs[3]  = '{0, 0, 0, 1, 0, 0,              1, 64'h8,  1, 64'h4, memWord(4)};
      vecs[4]  = '{0, 0, 0, 1, 1, memWord(8),     1, 64'hC,  0, 0, 0};
      vecs[5]  = '{0, 0, 0, 1, 1, memWord(12),    0, 0,      1, 64'h8, memWord(8)};
      vecs[6]  = '{1, 0, 0, 0, 0, 0,              1, 64'h0,  0, 0, 0};
      vecs[7]  = '{0, 1, 64'h83, 0, 1, memWord(0), 0, 0,     0, 0, 0};
      vecs[8]  = '{0, 0, 0, 0, 0, 0,              1, 64'h80, 0, 0, 0};
      vecs[9]  = '{0, 0, 0, 0, 1, memWord(64'h80), 1, 64'h84, 0, 0, 0};
      vecs[10] = '{0, 0, 0, 0, 0, 0,              0, 0,      1, 64'h80, memWord(64'h80)};

      foreach (vecs[i]) begin
         if (vecs[i].doReset) doReset();
         imem_ack    = vecs[i].ack;
         imem_rdata  = vecs[i].rdata;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         id_ready    = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d.req", i), 64'(imem_req), 64'(vecs[i].expReq));
         if (vecs[i].expReq) check($sformatf("vec%0d.addr", i), imem_addr, vecs[i].expAddr);
         check($sformatf("vec%0d.valid", i), 64'(IFID_valid), 64'(vecs[i].expValid));
         if (vecs[i].expValid) begin
            check($sformatf("vec%0d.pc", i), IFID_PC_Out, vecs[i].expPc);
            check($sformatf("vec%0d.instr", i), 64'(IFID_instruction), 64'(vecs[i].expInstr));
         end
         @(negedge clk);
      end

      // Decode stalls: buffer fills to DEPTH and fetch stops, then drains in order.
      doReset();
      fixedLat = 1;
      for (int i = 0; i < 3; i++) applyStimulus("bp.run", 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) applyStimulus("bp.stall", 0, 0, 0, 0);
      check("bp.full_no_req", 64'(imem_req), 64'd0);
      for (int i = 0; i < 10; i++) applyStimulus("bp.drain", 0, 0, 1, 0);

      // Redirect while the request for 8 is in flight: its response must be discarded.
      doReset();
      fixedLat = 3;
      bound = 0;
      while (!(outstanding && mReqAddr == 64'h8) && bound < 20) begin
         applyStimulus("kill.pre", 0, 0, 1, 0);
         bound++;
      end
      check("kill.reached_req8", 64'(bound < 20), 64'd1);
      applyStimulus("kill.redir", 1, 64'h40, 1, 0);
      startPops = popCount;
      obsReqCount = 0;
      bound = 0;
      while (obsReqCount == 0 && bound < 10) begin
         applyStimulus("kill.wait", 0, 0, 1, 0);
         bound++;
      end
      check("kill.first_req", lastObsReqAddr, 64'h40);
      bound = 0;
      while (popCount == startPops && bound < 20) begin
         applyStimulus("kill.drain", 0, 0, 1, 0);
         bound++;
      end
      check("kill.first_pc", lastPopPc, 64'h40);

      // Three-cycle memory: one request every third cycle.
      doReset();
      fixedLat = 3;
      obsReqCount = 0;
      for (int i = 0; i < 30; i++) applyStimulus("lat3", 0, 0, 1, 0);
      check("lat3.req_count", 64'(obsReqCount), 64'd10);

      // Reset mid-WAIT clears outputs without a clock, and a late ack is ignored.
      doReset();
      fixedLat = 2;
      bound = 0;
      while (!(outstanding && modelQ.size() > 0) && bound < 20) begin
         applyStimulus("rst.pre", 0, 0, 0, 0);
         bound++;
      end
      check("rst.reached_wait", 64'(bound < 20), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rst.async_valid", 64'(IFID_valid), 64'd0);
      check("rst.async_req", 64'(imem_req), 64'd0);
      check("rst.async_addr", imem_addr, RESET_PC);
      check("rst.async_instr", 64'(IFID_instruction), 64'd0);
      check("rst.async_pc", IFID_PC_Out, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      resetModel();
      applyStimulus("rst.late_ack", 0, 0, 1, 1);
      for (int i = 0; i < 8; i++) applyStimulus("rst.post", 0, 0, 1, 0);

      // Randomized traffic: variable latency, stalls, redirects, including near the top of memory.
      doReset();
      fixedLat = 0;
      for (int i = 0; i < 400; i++) begin
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         applyStimulus("rand", $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 9) < 7, 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
